// File: rtl/spike_rate_decoder.sv
// Converts a spike train into an 8-bit firing rate by counting rising edges
// over a WINDOW-cycle window and presenting each count on a valid/ready port.
module spike_rate_decoder #(
    parameter logic [23:0] WINDOW = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       spike_in,
    output logic [7:0] rate_out,
    output logic       rate_sat,
    output logic       rate_valid,
    input  logic       rate_ready,
    output logic       overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } mode_t;

    localparam logic [23:0] LAST = WINDOW - 24'd1;

    mode_t       mode_s;
    logic        prev_r;
    logic [23:0] win_cnt_r;
    logic [23:0] win_cnt_s;
    logic [7:0]  acc_r;
    logic [7:0]  acc_s;
    logic [7:0]  acc_inc_s;
    logic        sat_r;
    logic        sat_s;
    logic        sat_inc_s;
    logic        edge_s;
    logic        win_end_s;
    logic        xfer_s;
    logic [7:0]  rate_out_s;
    logic        rate_sat_s;
    logic        rate_valid_s;
    logic        overrun_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    assign mode_s = ena ? COUNT : IDLE;

    // Next-state for window counter, accumulator, output register and handshake
    always_comb begin
        win_cnt_s    = 24'd0;
        acc_s        = 8'd0;
        sat_s        = 1'b0;
        rate_out_s   = rate_out;
        rate_sat_s   = rate_sat;
        rate_valid_s = rate_valid;
        overrun_s    = 1'b0;
        win_end_s    = 1'b0;
        edge_s       = spike_in & ~prev_r;
        acc_inc_s    = edge_s ? sat_inc(acc_r) : acc_r;
        // An edge landing on a full accumulator marks the window as saturated
        sat_inc_s    = sat_r | (edge_s & (acc_r == 8'hFF));
        xfer_s       = rate_valid & rate_ready;

        case (mode_s)
            IDLE: begin
                win_cnt_s = 24'd0;
            end
            COUNT: begin
                if (win_cnt_r >= LAST) begin
                    win_end_s  = 1'b1;
                    rate_out_s = acc_inc_s;
                    rate_sat_s = sat_inc_s;
                end else begin
                    win_cnt_s = win_cnt_r + 24'd1;
                    acc_s     = acc_inc_s;
                    sat_s     = sat_inc_s;
                end
            end
            default: begin
                win_cnt_s = 24'd0;
            end
        endcase

        // A window end wins over a transfer so fresh data is never dropped
        if (win_end_s) begin
            rate_valid_s = 1'b1;
            overrun_s    = rate_valid & ~rate_ready;
        end else if (xfer_s) begin
            rate_valid_s = 1'b0;
        end else begin
            rate_valid_s = rate_valid;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r     <= 1'b0;
            win_cnt_r  <= 24'd0;
            acc_r      <= 8'd0;
            sat_r      <= 1'b0;
            rate_out   <= 8'd0;
            rate_sat   <= 1'b0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            prev_r     <= spike_in;
            win_cnt_r  <= win_cnt_s;
            acc_r      <= acc_s;
            sat_r      <= sat_s;
            rate_out   <= rate_out_s;
            rate_sat   <= rate_sat_s;
            rate_valid <= rate_valid_s;
            overrun    <= overrun_s;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench: two decoders (WINDOW=16 and WINDOW=1024) driven window by
// window; expected rates are queued as spikes are driven and popped at window ends.
module tb_spike_rate_decoder;

    typedef struct packed {
        logic [7:0] rate;
        logic       sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena16 = 1'b0;
    logic ena1k = 1'b0;
    logic spike_in = 1'b0;
    logic rate_ready = 1'b0;
    logic [7:0] r16_out;
    logic r16_sat, r16_valid, r16_ovr;
    logic [7:0] r1k_out;
    logic r1k_sat, r1k_valid, r1k_ovr;

    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW(24'd16)) dut16 (
        .clk(clk), .rst(rst), .ena(ena16), .spike_in(spike_in),
        .rate_out(r16_out), .rate_sat(r16_sat), .rate_valid(r16_valid),
        .rate_ready(rate_ready), .overrun(r16_ovr)
    );

    spike_rate_decoder #(.WINDOW(24'd1024)) dut1k (
        .clk(clk), .rst(rst), .ena(ena1k), .spike_in(spike_in),
        .rate_out(r1k_out), .rate_sat(r1k_sat), .rate_valid(r1k_valid),
        .rate_ready(rate_ready), .overrun(r1k_ovr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart16();
        ena16 = 1'b0;
        spike_in = 1'b0;
        tick();
        ena16 = 1'b1;
    endtask

    task automatic window16(input logic [15:0] pat, input logic [15:0] rdy, input logic exp_ovr);
        int n = 0;
        logic last;
        logic pv;
        logic [7:0] ro0;
        exp_t e;
        last = spike_in;
        ro0 = r16_out;
        for (int i = 0; i < 16; i++) begin
            spike_in = pat[i];
            rate_ready = rdy[i];
            if (pat[i] && !last) n++;
            last = pat[i];
            if (i == 15) begin
                e.rate = (n > 255) ? 8'd255 : n[7:0];
                e.sat = (n > 255);
                sb.push_back(e);
            end
            pv = r16_valid;
            tick();
            if (i < 15) begin
                vectors++;
                if (r16_out !== ro0 || r16_ovr !== 1'b0 || r16_valid !== (pv & ~rdy[i])) begin
                    miscompares++;
                    $display("FAIL mid_window cycle %0d: out=%0d ovr=%b valid=%b, required out=%0d ovr=0 valid=%b",
                             i, r16_out, r16_ovr, r16_valid, ro0, pv & ~rdy[i]);
                end
            end
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got 0 entries, required 1");
        end else begin
            e = sb.pop_front();
            if (r16_valid !== 1'b1 || r16_out !== e.rate || r16_sat !== e.sat || r16_ovr !== exp_ovr) begin
                miscompares++;
                $display("FAIL window_end16: valid=%b out=%0d sat=%b ovr=%b, required valid=1 out=%0d sat=%b ovr=%b",
                         r16_valid, r16_out, r16_sat, r16_ovr, e.rate, e.sat, exp_ovr);
            end
        end
    endtask

    task automatic window1k(input int npulses);
        int n = 0;
        logic last;
        logic s;
        exp_t e;
        last = spike_in;
        rate_ready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            s = (i < 2 * npulses) && (i % 2 == 0);
            spike_in = s;
            if (s && !last) n++;
            last = s;
            if (i == 1023) begin
                e.rate = (n > 255) ? 8'd255 : n[7:0];
                e.sat = (n > 255);
                sb.push_back(e);
            end
            tick();
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got 0 entries, required 1");
        end else begin
            e = sb.pop_front();
            if (r1k_valid !== 1'b1 || r1k_out !== e.rate || r1k_sat !== e.sat || r1k_ovr !== 1'b0) begin
                miscompares++;
                $display("FAIL window_end1k: valid=%b out=%0d sat=%b ovr=%b, required valid=1 out=%0d sat=%b ovr=0",
                         r1k_valid, r1k_out, r1k_sat, r1k_ovr, e.rate, e.sat);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({r16_out, r16_sat, r16_valid, r16_ovr} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset16: got %h, required 000", {r16_out, r16_sat, r16_valid, r16_ovr});
        end
        vectors++;
        if ({r1k_out, r1k_sat, r1k_valid, r1k_ovr} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset1k: got %h, required 000", {r1k_out, r1k_sat, r1k_valid, r1k_ovr});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        restart16();
        window16(16'b0000_0010_0010_0100, 16'hFFFF, 1'b0);
        spike_in = 1'b0;
        tick();
        vectors++;
        if (r16_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_valid_drop: valid=%b, required 0", r16_valid);
        end
    endtask

    task automatic test_held_high();
        restart16();
        window16(16'b1000_0011_1111_1111, 16'hFFFF, 1'b0);
        window16(16'h0000, 16'hFFFF, 1'b0);
    endtask

    task automatic test_saturation();
        ena16 = 1'b0;
        spike_in = 1'b0;
        ena1k = 1'b1;
        window1k(300);
        window1k(0);
        window1k(255);
        ena1k = 1'b0;
    endtask

    task automatic test_overrun();
        restart16();
        window16(16'h0011, 16'h0000, 1'b0);
        window16(16'h0155, 16'h0000, 1'b1);
        spike_in = 1'b0;
        tick();
        vectors++;
        if (r16_ovr !== 1'b0 || r16_valid !== 1'b1 || r16_out !== 8'd5) begin
            miscompares++;
            $display("FAIL overrun_pulse: ovr=%b valid=%b out=%0d, required ovr=0 valid=1 out=5", r16_ovr, r16_valid, r16_out);
        end
        rate_ready = 1'b1;
        tick();
        vectors++;
        if (r16_valid !== 1'b0 || r16_out !== 8'd5) begin
            miscompares++;
            $display("FAIL overrun_drain: valid=%b out=%0d, required valid=0 out=5", r16_valid, r16_out);
        end
    endtask

    task automatic test_back_to_back();
        restart16();
        window16(16'h0001, 16'h0000, 1'b0);
        window16(16'h0015, 16'h8000, 1'b0);
        rate_ready = 1'b0;
        spike_in = 1'b0;
        tick();
        vectors++;
        if (r16_valid !== 1'b1 || r16_ovr !== 1'b0 || r16_out !== 8'd3) begin
            miscompares++;
            $display("FAIL coincident_hold: valid=%b ovr=%b out=%0d, required valid=1 ovr=0 out=3", r16_valid, r16_ovr, r16_out);
        end
        rate_ready = 1'b1;
        tick();
        vectors++;
        if (r16_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL coincident_drain: valid=%b, required 0", r16_valid);
        end
    endtask

    task automatic test_abort_ena();
        restart16();
        rate_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            spike_in = (i % 2 == 0);
            tick();
        end
        ena16 = 1'b0;
        spike_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (r16_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_ena_no_emit: valid=%b, required 0", r16_valid);
            end
        end
        ena16 = 1'b1;
        window16(16'h0004, 16'hFFFF, 1'b0);
    endtask

    task automatic test_abort_rst();
        restart16();
        rate_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            spike_in = (i % 2 == 0);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({r16_out, r16_sat, r16_valid, r16_ovr} !== 11'd0) begin
            miscompares++;
            $display("FAIL abort_rst_values: got %h, required 000", {r16_out, r16_sat, r16_valid, r16_ovr});
        end
        rst = 1'b0;
        window16(16'h0004, 16'hFFFF, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_held_high();
        test_saturation();
        test_overrun();
        test_back_to_back();
        test_abort_ena();
        test_abort_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Receive-side companion to the neuron core: it converts an incoming spike train back into an 8-bit firing-rate value. It counts rising edges on a spike line over a fixed window of `WINDOW` clock cycles. At each window boundary it presents the count on a valid/ready output port. It sits between a neuron's spike output and whatever consumes rates (7-segment driver, STDP logic, scan-out), mirroring the rate encoder that drives neuron inputs.

## Interface
- `WINDOW`, default `24'd10_000_000`: window length in clock cycles. Legal range is 2 to 2^24−1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  decoder enable. When low, window and accumulator are cleared and held at 0.
- `spike_in`  in  1  spike line, synchronous to `clk`. A 0→1 transition is one spike.
- `rate_out`  out  8  captured spike count of the last completed window.
- `rate_sat`  out  1  set when the window's count saturated at 255; qualifies `rate_out`.
- `rate_valid`  out  1  `rate_out`/`rate_sat` hold an unconsumed value.
- `rate_ready`  in  1  consumer accepts the value on a rising edge where `rate_valid`=1.
- `overrun`  out  1  one-cycle pulse: an unconsumed value was overwritten.

## Operation
- **Reset values** (`rst`=1, asynchronous): `rate_out`=0, `rate_sat`=0, `rate_valid`=0, `overrun`=0. Window counter, accumulator, saturation flag and edge-history register are also 0.
- **Edge detection**
  - `prev` samples `spike_in` every cycle, regardless of `ena`.
  - A spike is counted when `spike_in`=1, `prev`=0 and `ena`=1.
  - A level held high for N cycles counts once.
  - A line already high when `ena` rises does not count.
- **Window counter** (24 bits)
  - Increments while `ena`=1 and wraps from `WINDOW`−1 to 0.
  - `ena`=0 forces counter, accumulator and saturation flag to 0 on the next edge.
  - The output register and handshake are not affected by `ena`.
- **Accumulator** (8 bits)
  - Increments on each counted edge and saturates at 255.
  - An edge arriving while the accumulator is at 255 sets the saturation flag.
- **Window end**: the edge where `ena`=1 and counter=`WINDOW`−1. On that edge:
  - `rate_out` ← accumulator value including any edge detected on that same cycle, saturated.
  - `rate_sat` ← saturation flag, likewise including that cycle.
  - `rate_valid` ← 1.
  - Accumulator and saturation flag restart at 0 for the new window.
- **Handshake**
  - A transfer occurs on any edge with `rate_valid`=1 and `rate_ready`=1.
  - After a transfer, `rate_valid` falls on that same edge, unless a window end coincides.
  - Transfer coinciding with a window end: `rate_valid` stays 1 with the new data and `overrun` stays 0.
  - Window end while `rate_valid`=1 and `rate_ready`=0: data is overwritten, `rate_valid` stays 1, and `overrun` pulses high for exactly one cycle.
  - `rate_out` and `rate_sat` change only at a window end or at reset.
- **State**: two implicit states, IDLE (`ena`=0, all counting state cleared) and COUNT (`ena`=1). Transitions take effect at the `clk` edge on which `ena` is sampled.

## Timing
- With `ena` high continuously from the first edge after reset release, the first window end is the `WINDOW`-th rising edge. Window ends then repeat every `WINDOW` cycles.
- Spike-to-count latency is 1 edge. `rate_valid` becomes visible right after the window-end edge.
- Max countable rate is one spike per 2 cycles, so saturation requires `WINDOW` ≥ 511.
- Reset asserted mid-window: immediate return to reset values. The first window after release is a full `WINDOW` cycles, with no partial result.
- `ena` dropped mid-window: the partial count is discarded and no value is emitted. A pending `rate_valid` remains until accepted.

## Test plan
- `WINDOW`=16, `rate_ready`=1, `ena`=1; 3 single-cycle pulses in window 1 → `rate_valid` high for 1 cycle after edge 16, `rate_out`=3, `rate_sat`=0, `overrun`=0.
- `WINDOW`=16; `spike_in` held high for 10 cycles, plus one 0→1 edge on the last window cycle → `rate_out`=2. The next window, with no new edges, yields `rate_out`=0.
- `WINDOW`=1024; 300 alternating-cycle pulses → `rate_out`=255, `rate_sat`=1. The following empty window gives `rate_out`=0, `rate_sat`=0.
- `WINDOW`=16, `rate_ready`=0; windows with 2 then 5 spikes → `overrun` pulses once at the second window end and `rate_out`=5. Raising `rate_ready` transfers 5 and drops `rate_valid` the same edge.
- `WINDOW`=16; `rate_ready` pulse coincident with a window end → `rate_valid` stays 1, new value loaded, no `overrun`.
- `WINDOW`=16; 4 spikes, then `ena`=0 at cycle 8 (or `rst` pulse at cycle 8), then re-enable with 1 spike → no emission for the aborted window. The next emission occurs 16 cycles after re-enable with `rate_out`=1.
